freq_meter: RTL
===============

# freq_meter

Measures the frequency of a slow asynchronous signal by counting its rising edges over a fixed gate window of system-clock cycles. It is the inverse of the clock divider: the divider turns the system clock into slower taps, and this block turns a tap, a pin or a debug strobe back into a number. Its intended uses are board bring-up and self-checking the divider taps. The count feeds the seven-segment and debug display path.

## Interface
Parameters:
- `GATE_CYCLES`, default 200_000_000: gate window length in `clk` cycles. Must be ≥ 2. The default gives a 1 s window at 200 MHz.
- `CNT_W`, default 32: width of the edge counter and result.
- `SYNC_STAGES`, default 2: synchronizer flops on `sig_in`. Must be ≥ 2.

Ports:
- `clk`  in  1: system clock. Single clock domain.
- `rst`  in  1: synchronous, active-high reset.
- `sig_in`  in  1: asynchronous signal under measurement.
- `start`  in  1: single-cycle request to begin a measurement.
- `continuous`  in  1: when high, windows repeat back-to-back.
- `busy`  out  1: a window is in progress.
- `count`  out  CNT_W: rising-edge count of the last completed window.
- `count_valid`  out  1: one-cycle pulse when `count` updates.
- `overflow`  out  1: the last completed window saturated.
- `period`  out  CNT_W: `clk` cycles between the two most recent rising edges (see Configuration).
- `period_valid`  out  1: one-cycle pulse when `period` updates.

## Operation
- `sig_in` passes through a `SYNC_STAGES` flop chain. A rising edge is detected when the previous synchronized value is 0 and the current one is 1.
- FSM states are IDLE and MEASURE.
  - IDLE → MEASURE on `start`. Clear the gate counter and edge counter at this transition.
  - In MEASURE, the gate counter runs 0..`GATE_CYCLES`-1. Each detected edge increments the edge counter.
  - At gate = `GATE_CYCLES`-1, latch the result into `count`/`overflow` and pulse `count_valid`.
  - After that latch, go to MEASURE with cleared counters if `continuous`=1 (sampled in that same cycle), otherwise go to IDLE.
- The edge counter saturates at 2^CNT_W−1 and sets an internal overflow flag. Do not wrap.
- An edge detected in the final gate cycle counts toward the current window.
- An edge in the first cycle of the next window counts toward the next window. There is no dead cycle in continuous mode.
- `start` is ignored while `busy`=1.
- Dropping `continuous` mid-window finishes the current window, then returns to IDLE.
- `rst` mid-window:
  - Return to IDLE immediately.
  - Discard the partial count. Hold `count` and `overflow` at 0.
  - Clear the synchronizer flops to 0.
  - Do not emit a `count_valid` pulse.
- Reset values: `busy`=0, `count`=0, `count_valid`=0, `overflow`=0, `period`=0, `period_valid`=0.

## Timing
- A `sig_in` rising edge reaches the edge counter `SYNC_STAGES`+1 cycles after it is sampled high.
- `busy` goes to 1 in the cycle after `start`.
- `count`/`count_valid` are registered. They appear in the cycle after the final gate cycle, which is `GATE_CYCLES`+1 cycles after the `start` cycle.
- `busy` falls in the same cycle as `count_valid` when not continuous. It stays 1 in continuous mode.
- `count_valid` and `period_valid` are exactly one cycle wide and independent. They may coincide.
- Maximum countable edge rate: one edge per 2 `clk` cycles. Faster inputs undercount. This behaviour is defined, not an error.

## Configuration
- `FREQ_METER_PERIOD_EN` defined:
  - A free-running cycle counter, saturating at 2^CNT_W−1, restarts at each detected edge.
  - On each edge after the first one since reset, its pre-restart value plus 1 is latched into `period` and `period_valid` pulses.
  - Period measurement is independent of the FSM and runs in IDLE.
- Not defined: `period` and `period_valid` remain ports, tied to 0. No period logic is synthesized.

## Structure
- `freq_meter_pkg` holds:
  - the FSM state enum (`FM_IDLE`, `FM_MEASURE`);
  - the default width constant `FM_CNT_W_DEF` = 32;
  - the default gate constant `FM_GATE_DEF`.
- Sub-module `edge_sync` contains the parameterized synchronizer chain and rising-edge detector. It outputs a one-cycle `rise` pulse and is reusable for buttons.
- Gate counter width is `$clog2(GATE_CYCLES)`.

## Test plan
- `GATE_CYCLES`=100; `sig_in` toggles every 5 cycles; single `start` → one `count_valid` with `count`=10, `overflow`=0, then `busy`=0.
- Same stimulus with `continuous`=1 for 3 windows → three `count_valid` pulses exactly 100 cycles apart, each with `count`=10.
- `CNT_W`=4, `GATE_CYCLES`=100, `sig_in` period 4 → `count`=15, `overflow`=1.
- `rst` asserted 50 cycles into a window → `busy`=0, `count`=0 the next cycle, and no `count_valid`. A new `start` then yields `count`=10.
- `start` pulsed again mid-window → ignored. A single `count_valid` arrives at cycle 101.
- With `FREQ_METER_PERIOD_EN` and `sig_in` period 10 → from the second edge on, `period`=10 with a `period_valid` pulse every 10 cycles, including while in IDLE.

Source files
------------

// File: rtl/freq_meter_pkg.sv
// Shared types and defaults for the frequency meter.
package freq_meter_pkg;

    localparam int unsigned FM_CNT_W_DEF = 32;
    localparam int unsigned FM_GATE_DEF  = 200_000_000;

    typedef enum logic {
        FM_IDLE    = 1'b0,
        FM_MEASURE = 1'b1
    } fm_state_e;

endpackage

// File: rtl/edge_sync.sv
// Synchronizer chain plus registered rising-edge detector; reusable for buttons.
// rise_o pulses for one cycle, STAGES+1 cycles after sig_i is first sampled high.
module edge_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic sig_i,
    output logic rise_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;
    logic              rise_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], sig_i};
            prev_q <= sync_q[STAGES-1];
            rise_q <= sync_q[STAGES-1] & ~prev_q;
        end
    end

    assign rise_o = rise_q;

endmodule

// File: rtl/freq_meter.sv
// Counts rising edges of an asynchronous input over a fixed gate window.
// Optional period measurement is enabled by defining FREQ_METER_PERIOD_EN.
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int unsigned GATE_CYCLES = FM_GATE_DEF,
    parameter int unsigned CNT_W       = FM_CNT_W_DEF,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sig_in,
    input  logic             start,
    input  logic             continuous,
    output logic             busy,
    output logic [CNT_W-1:0] count,
    output logic             count_valid,
    output logic             overflow,
    output logic [CNT_W-1:0] period,
    output logic             period_valid
);

    localparam int unsigned        GATE_W    = $clog2(GATE_CYCLES);
    localparam logic [GATE_W-1:0]  GATE_LAST = GATE_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0]   CNT_MAX   = '1;

    logic rise;

    edge_sync #(
        .STAGES (SYNC_STAGES)
    ) u_edge_sync (
        .clk    (clk),
        .rst    (rst),
        .sig_i  (sig_in),
        .rise_o (rise)
    );

    fm_state_e         state_q;
    logic [GATE_W-1:0] gate_q;
    logic [CNT_W-1:0]  edges_q;
    logic [CNT_W-1:0]  edges_d;
    logic              ovf_q;
    logic              ovf_d;
    logic              busy_q;
    logic [CNT_W-1:0]  count_q;
    logic              count_valid_q;
    logic              overflow_q;

    // Saturating edge count including the edge seen in the current cycle.
    assign edges_d = (rise && (edges_q != CNT_MAX)) ? edges_q + CNT_W'(1) : edges_q;
    assign ovf_d   = ovf_q | (rise & (edges_q == CNT_MAX));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= FM_IDLE;
            busy_q        <= 1'b0;
            gate_q        <= '0;
            edges_q       <= '0;
            ovf_q         <= 1'b0;
            count_q       <= '0;
            count_valid_q <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            count_valid_q <= 1'b0;
            case (state_q)
                FM_IDLE: begin
                    if (start) begin
                        state_q <= FM_MEASURE;
                        busy_q  <= 1'b1;
                        gate_q  <= '0;
                        edges_q <= '0;
                        ovf_q   <= 1'b0;
                    end
                end
                FM_MEASURE: begin
                    if (gate_q == GATE_LAST) begin
                        // Final gate cycle: publish and restart without a dead cycle.
                        count_q       <= edges_d;
                        overflow_q    <= ovf_d;
                        count_valid_q <= 1'b1;
                        gate_q        <= '0;
                        edges_q       <= '0;
                        ovf_q         <= 1'b0;
                        if (!continuous) begin
                            state_q <= FM_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        gate_q  <= gate_q + GATE_W'(1);
                        edges_q <= edges_d;
                        ovf_q   <= ovf_d;
                    end
                end
                default: begin
                    state_q <= FM_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign count       = count_q;
    assign count_valid = count_valid_q;
    assign overflow    = overflow_q;

`ifdef FREQ_METER_PERIOD_EN
    logic [CNT_W-1:0] per_cnt_q;
    logic [CNT_W-1:0] period_q;
    logic             period_valid_q;
    logic             seen_q;

    // Free-running edge-to-edge cycle counter, independent of the gate FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            per_cnt_q      <= '0;
            period_q       <= '0;
            period_valid_q <= 1'b0;
            seen_q         <= 1'b0;
        end else begin
            period_valid_q <= 1'b0;
            if (rise) begin
                per_cnt_q <= '0;
                seen_q    <= 1'b1;
                if (seen_q) begin
                    period_q       <= (per_cnt_q == CNT_MAX) ? CNT_MAX : per_cnt_q + CNT_W'(1);
                    period_valid_q <= 1'b1;
                end
            end else if (per_cnt_q != CNT_MAX) begin
                per_cnt_q <= per_cnt_q + CNT_W'(1);
            end
        end
    end

    assign period       = period_q;
    assign period_valid = period_valid_q;
`else
    assign period       = '0;
    assign period_valid = 1'b0;
`endif

endmodule
